gpu_cache_fill_arbiter: RTL and testbench

- Services line-fill requests from the texture cache (Tex$) and the palette cache (Clut$) in the GPU pixel pipe.
- Both requests share one VRAM read port. The block arbitrates between them and issues one burst read per request.
- It streams the returned words into the winning cache with a word index, then pulses that cache's completion signal so the pipeline can resume.
- It sits between the pipe controller's requ*CacheUpdate/adr*CacheUpdate outputs and the memory controller.

---
 rtl/gpu_cache_pkg.sv | 37 +++
 rtl/gpu_rr_arb2.sv | 41 ++++
 rtl/gpu_cache_fill_arbiter.sv | 118 +++++++++++
 tb/tb_gpu_cache_fill_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_cache_pkg.sv
// Shared types and constants for the GPU pixel-pipe cache fill path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, fill source enum, line sizes and the latched fill descriptor.
package gpu_cache_pkg;

  localparam int TEX_WORDS  = 2;   // 32-bit words per Tex$ line (8 bytes)
  localparam int CLUT_WORDS = 8;   // 32-bit words per Clut$ line (32 bytes)
  localparam int MEM_ADR_W  = 18;  // VRAM word address width (1 MB)
  localparam int CNT_W      = 4;   // beat counter / burst length width

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DATA,
    DONE,
    HOLD
  } state_t;

  typedef enum logic {
    SRC_TEX,
    SRC_CLUT
  } src_t;

  // Everything about the current fill that must stay stable from grant to completion.
  typedef struct packed {
    src_t                 src;
    logic [MEM_ADR_W-1:0] adr;
    logic [CNT_W-1:0]     len;
  } fill_t;

  function automatic logic [CNT_W-1:0] fill_len(input src_t src);
    if (src == SRC_CLUT) return CNT_W'(CLUT_WORDS);
    return CNT_W'(TEX_WORDS);
  endfunction

endpackage

// File: rtl/gpu_rr_arb2.sv
// Two-way round-robin picker between the Tex$ and Clut$ fill requests.
// Latency: grant is combinational from the requests; lastGrant updates on the grant edge.
// Backpressure: grants only while i_en is high; requests simply wait otherwise.
// Ports: clk/i_rst, i_en (arbitration window), i_reqTex/i_reqClut (levels),
//        o_gntVld (a grant is taken this cycle), o_gntSrc (winner).
module gpu_rr_arb2
  import gpu_cache_pkg::*;
(
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_reqTex,
  input  logic i_reqClut,
  output logic o_gntVld,
  output src_t o_gntSrc
);

  src_t r_lastGrant;

  always_comb begin
    o_gntVld = i_en && (i_reqTex || i_reqClut);
    o_gntSrc = SRC_TEX;
    if (i_reqTex && i_reqClut) begin
      // Tie: favour whoever did not win last time.
      if (r_lastGrant == SRC_TEX) o_gntSrc = SRC_CLUT;
      else                        o_gntSrc = SRC_TEX;
    end else if (i_reqClut) begin
      o_gntSrc = SRC_CLUT;
    end
  end

  // Resetting to TEX means Clut$ wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_lastGrant <= SRC_TEX;
    end else if (o_gntVld) begin
      r_lastGrant <= o_gntSrc;
    end
  end

endmodule

// File: rtl/gpu_cache_fill_arbiter.sv
// Arbitrates Tex$/Clut$ line fills onto one VRAM burst-read port and streams beats into the winner.
// Latency: o_memReq 1 cycle after grant; each write strobe 1 cycle after its beat; complete with last write.
// Backpressure: o_memReq held until i_memAck; beats may have gaps; losing request waits in IDLE.
// Ports: i_requTex/i_adrTex, i_requClut/i_adrClut (level requests + line addresses);
//        o_memReq/o_memAdr/o_memLen/i_memAck, i_memDataValid/i_memData (memory side);
//        o_texWr/o_clutWr/o_wrIdx/o_wrData, o_texComplete/o_clutComplete (cache side); o_busy.
module gpu_cache_fill_arbiter
  import gpu_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_requTex,
  input  logic [MEM_ADR_W-2:0] i_adrTex,
  input  logic                 i_requClut,
  input  logic [MEM_ADR_W-4:0] i_adrClut,
  output logic                 o_memReq,
  output logic [MEM_ADR_W-1:0] o_memAdr,
  output logic [CNT_W-1:0]     o_memLen,
  input  logic                 i_memAck,
  input  logic                 i_memDataValid,
  input  logic [31:0]          i_memData,
  output logic                 o_texWr,
  output logic                 o_clutWr,
  output logic [2:0]           o_wrIdx,
  output logic [31:0]          o_wrData,
  output logic                 o_texComplete,
  output logic                 o_clutComplete,
  output logic                 o_busy
);

  state_t           r_state;
  state_t           w_stateNext;
  fill_t            r_fill;
  fill_t            w_fillNew;
  logic [CNT_W-1:0] r_cnt;
  logic             r_texWr;
  logic             r_clutWr;
  logic [2:0]       r_wrIdx;
  logic [31:0]      r_wrData;

  logic             w_gntVld;
  src_t             w_gntSrc;
  logic             w_beat;
  logic             w_lastBeat;

  gpu_rr_arb2 u_arb (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_en      (r_state == IDLE),
    .i_reqTex  (i_requTex),
    .i_reqClut (i_requClut),
    .o_gntVld  (w_gntVld),
    .o_gntSrc  (w_gntSrc)
  );

  // Beats only count in DATA; anything presented in IDLE/REQ (including the ack cycle) is dropped.
  assign w_beat     = (r_state == DATA) && i_memDataValid;
  assign w_lastBeat = w_beat && (r_cnt == r_fill.len - CNT_W'(1));

  // Line address to VRAM word address: Tex$ lines are 2 words, Clut$ lines are 8 words.
  always_comb begin
    w_fillNew.src = w_gntSrc;
    w_fillNew.len = fill_len(w_gntSrc);
    if (w_gntSrc == SRC_CLUT) w_fillNew.adr = {i_adrClut, 3'b000};
    else                      w_fillNew.adr = {i_adrTex, 1'b0};
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_gntVld)   w_stateNext = REQ;
      REQ:     if (i_memAck)   w_stateNext = DATA;
      DATA:    if (w_lastBeat) w_stateNext = DONE;
      DONE:                    w_stateNext = HOLD;
      // The requester may still show its stale level for one cycle after complete.
      HOLD:                    w_stateNext = IDLE;
      default:                 w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_fill   <= '0;
      r_cnt    <= '0;
      r_texWr  <= 1'b0;
      r_clutWr <= 1'b0;
      r_wrIdx  <= '0;
      r_wrData <= '0;
    end else begin
      r_state <= w_stateNext;
      if ((r_state == IDLE) && w_gntVld) r_fill <= w_fillNew;

      if ((r_state == REQ) && i_memAck) r_cnt <= '0;
      else if (w_beat)                  r_cnt <= r_cnt + CNT_W'(1);

      r_texWr  <= w_beat && (r_fill.src == SRC_TEX);
      r_clutWr <= w_beat && (r_fill.src == SRC_CLUT);
      if (w_beat) begin
        r_wrIdx  <= r_cnt[2:0];
        r_wrData <= i_memData;
      end
    end
  end

  // DONE is entered on the edge that registers the last write, so complete lines up with it.
  assign o_memReq       = (r_state == REQ);
  assign o_memAdr       = r_fill.adr;
  assign o_memLen       = r_fill.len;
  assign o_texWr        = r_texWr;
  assign o_clutWr       = r_clutWr;
  assign o_wrIdx        = r_wrIdx;
  assign o_wrData       = r_wrData;
  assign o_texComplete  = (r_state == DONE) && (r_fill.src == SRC_TEX);
  assign o_clutComplete = (r_state == DONE) && (r_fill.src == SRC_CLUT);
  assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_gpu_cache_fill_arbiter.sv
module tb_gpu_cache_fill_arbiter;
  import gpu_cache_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_requTex = 1'b0;
  logic [16:0] i_adrTex = '0;
  logic        i_requClut = 1'b0;
  logic [14:0] i_adrClut = '0;
  logic        o_memReq;
  logic [17:0] o_memAdr;
  logic [3:0]  o_memLen;
  logic        i_memAck = 1'b0;
  logic        i_memDataValid = 1'b0;
  logic [31:0] i_memData = '0;
  logic        o_texWr, o_clutWr;
  logic [2:0]  o_wrIdx;
  logic [31:0] o_wrData;
  logic        o_texComplete, o_clutComplete, o_busy;

  always #5 clk = ~clk;

  gpu_cache_fill_arbiter dut (
    .clk            (clk),
    .i_rst          (i_rst),
    .i_requTex      (i_requTex),
    .i_adrTex       (i_adrTex),
    .i_requClut     (i_requClut),
    .i_adrClut      (i_adrClut),
    .o_memReq       (o_memReq),
    .o_memAdr       (o_memAdr),
    .o_memLen       (o_memLen),
    .i_memAck       (i_memAck),
    .i_memDataValid (i_memDataValid),
    .i_memData      (i_memData),
    .o_texWr        (o_texWr),
    .o_clutWr       (o_clutWr),
    .o_wrIdx        (o_wrIdx),
    .o_wrData       (o_wrData),
    .o_texComplete  (o_texComplete),
    .o_clutComplete (o_clutComplete),
    .o_busy         (o_busy)
  );

  typedef struct {
    bit          clut;
    logic [2:0]  idx;
    logic [31:0] dat;
    bit          last;
  } wr_t;

  typedef struct {
    logic [17:0] adr;
    logic [3:0]  len;
  } burst_t;

  wr_t         exp_wr_q[$];
  burst_t      exp_burst_q[$];
  logic [31:0] beat_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Queue one fill: the burst it must issue, the beats memory returns, the writes it must make.
  task automatic push_fill(input bit clut, input logic [17:0] adr, input int len,
                           input logic [31:0] base, input int nwr);
    burst_t b;
    wr_t    w;
    b.adr = adr;
    b.len = 4'(len);
    exp_burst_q.push_back(b);
    for (int i = 0; i < nwr; i++) begin
      w.clut = clut;
      w.idx  = 3'(i);
      w.dat  = base + 32'(i);
      w.last = (i == len - 1);
      exp_wr_q.push_back(w);
      beat_q.push_back(base + 32'(i));
    end
  endtask

  // Monitor: every write strobe and every new burst request is popped against the scoreboard.
  wr_t    mon_e;
  burst_t mon_b;
  logic   prev_req = 1'b0;

  always @(negedge clk) begin
    if (o_texWr || o_clutWr) begin
      chk("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
      if (exp_wr_q.size() != 0) begin
        mon_e = exp_wr_q.pop_front();
        chk("wr_kind", 32'({o_texWr, o_clutWr}), mon_e.clut ? 32'd1 : 32'd2);
        chk("wr_idx", 32'(o_wrIdx), 32'(mon_e.idx));
        chk("wr_dat", o_wrData, mon_e.dat);
        chk("wr_cmpl", 32'({o_texComplete, o_clutComplete}),
            mon_e.last ? (mon_e.clut ? 32'd1 : 32'd2) : 32'd0);
      end
    end else if (o_texComplete || o_clutComplete) begin
      chk("cmpl_without_wr", 32'({o_texComplete, o_clutComplete}), 32'd0);
    end
    if (o_memReq && !prev_req) begin
      chk("burst_expected", 32'(exp_burst_q.size() != 0), 32'd1);
      if (exp_burst_q.size() != 0) begin
        mon_b = exp_burst_q.pop_front();
        chk("burst_adr", 32'(o_memAdr), 32'(mon_b.adr));
        chk("burst_len", 32'(o_memLen), 32'(mon_b.len));
      end
    end
    prev_req = o_memReq;
  end

  task automatic wait_req();
    int t = 0;
    @(negedge clk);
    while (!o_memReq && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("memreq_seen", 32'(o_memReq), 32'd1);
  endtask

  // Memory responder: ack after ack_dly cycles, then beats with gap idle cycles between them.
  // stray drives junk valids through REQ and the ack cycle; abort_after>0 resets after that beat.
  task automatic serve(input int ack_dly, input int gap, input int nbeats,
                       input bit stray, input int abort_after);
    wait_req();
    @(posedge clk); #1;
    for (int i = 0; i < ack_dly; i++) begin
      if (stray) begin
        i_memDataValid = 1'b1;
        i_memData      = 32'hDEAD0000 + 32'(i);
      end
      @(posedge clk); #1;
    end
    i_memAck = 1'b1;
    if (stray) begin
      i_memDataValid = 1'b1;
      i_memData      = 32'hDEADBEEF;
    end
    @(posedge clk); #1;
    i_memAck       = 1'b0;
    i_memDataValid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      repeat (gap) begin
        @(posedge clk); #1;
      end
      i_memDataValid = 1'b1;
      i_memData      = (beat_q.size() != 0) ? beat_q.pop_front() : 32'h0;
      @(posedge clk); #1;
      i_memDataValid = 1'b0;
      if (abort_after == i + 1) begin
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_cmpl(input bit clut);
    int t = 0;
    @(negedge clk);
    while (!(clut ? o_clutComplete : o_texComplete) && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("cmpl_seen", 32'(clut ? o_clutComplete : o_texComplete), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("rst_memReq", 32'(o_memReq), 32'd0);
    chk("rst_memAdr", 32'(o_memAdr), 32'd0);
    chk("rst_memLen", 32'(o_memLen), 32'd0);
    chk("rst_wr", 32'({o_texWr, o_clutWr}), 32'd0);
    chk("rst_wrIdx", 32'(o_wrIdx), 32'd0);
    chk("rst_wrData", o_wrData, 32'd0);
    chk("rst_cmpl", 32'({o_texComplete, o_clutComplete}), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);

    // Simultaneous and held requests: CLUT wins first tie, then strict alternation.
    push_fill(1'b1, 18'h3FFF8, 8, 32'hC0000000, 8);
    push_fill(1'b0, 18'h1579A, 2, 32'hB0000000, 2);
    push_fill(1'b1, 18'h3FFF8, 8, 32'hC1000000, 8);
    push_fill(1'b0, 18'h1579A, 2, 32'hB1000000, 2);
    @(posedge clk); #1;
    i_adrTex   = 17'h0ABCD;
    i_adrClut  = 15'h7FFF;
    i_requTex  = 1'b1;
    i_requClut = 1'b1;
    serve(0, 0, 8, 1'b0, 0); wait_cmpl(1'b1);
    serve(0, 1, 2, 1'b0, 0); wait_cmpl(1'b0);
    serve(3, 0, 8, 1'b0, 0); wait_cmpl(1'b1);
    serve(0, 0, 2, 1'b0, 0); wait_cmpl(1'b0);
    @(posedge clk); #1;
    i_requTex  = 1'b0;
    i_requClut = 1'b0;
    repeat (4) @(negedge clk);
    chk("alt_idle_busy", 32'(o_busy), 32'd0);

    // Tex only, address changes after grant must not disturb the burst.
    push_fill(1'b0, 18'h00246, 2, 32'hAAAA0001, 2);
    @(posedge clk); #1;
    i_adrTex  = 17'h00123;
    i_requTex = 1'b1;
    @(posedge clk); #1;
    i_adrTex = 17'h1FFFF;
    @(negedge clk);
    chk("adr_hold", 32'(o_memAdr), 32'h00246);
    serve(2, 0, 2, 1'b0, 0); wait_cmpl(1'b0);
    @(posedge clk); #1 i_requTex = 1'b0;

    // Clut only with 2-cycle gaps between beats.
    push_fill(1'b1, 18'h00A18, 8, 32'hC1D00000, 8);
    @(posedge clk); #1;
    i_adrClut  = {9'd5, 6'd3};
    i_requClut = 1'b1;
    serve(1, 2, 8, 1'b0, 0); wait_cmpl(1'b1);
    @(posedge clk); #1 i_requClut = 1'b0;

    // Request still high during HOLD must not start a second burst.
    push_fill(1'b0, 18'h00002, 2, 32'h44440000, 2);
    @(posedge clk); #1;
    i_adrTex  = 17'h00001;
    i_requTex = 1'b1;
    serve(0, 0, 2, 1'b0, 0); wait_cmpl(1'b0);
    repeat (2) @(posedge clk);
    #1 i_requTex = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_no_req", 32'(o_memReq), 32'd0);
    end
    chk("hold_busy", 32'(o_busy), 32'd0);

    // Stray beats in IDLE, then during REQ and on the ack cycle.
    @(posedge clk); #1;
    i_memDataValid = 1'b1;
    i_memData      = 32'h5EEDF00D;
    repeat (3) @(posedge clk);
    #1 i_memDataValid = 1'b0;
    @(negedge clk);
    chk("idle_stray_wr", 32'({o_texWr, o_clutWr}), 32'd0);
    chk("idle_stray_busy", 32'(o_busy), 32'd0);
    push_fill(1'b0, 18'h20000, 2, 32'h55550000, 2);
    @(posedge clk); #1;
    i_adrTex  = 17'h10000;
    i_requTex = 1'b1;
    serve(3, 0, 2, 1'b1, 0); wait_cmpl(1'b0);
    @(posedge clk); #1 i_requTex = 1'b0;

    // Reset after 3 of 8 Clut beats: fill abandoned, no complete.
    push_fill(1'b1, 18'h00208, 8, 32'h66660000, 3);
    @(posedge clk); #1;
    i_adrClut  = {9'd1, 6'd1};
    i_requClut = 1'b1;
    serve(0, 0, 8, 1'b0, 3);
    i_requClut = 1'b0;
    @(negedge clk);
    chk("abort_memReq", 32'(o_memReq), 32'd0);
    chk("abort_memAdr", 32'(o_memAdr), 32'd0);
    chk("abort_memLen", 32'(o_memLen), 32'd0);
    chk("abort_wr", 32'({o_texWr, o_clutWr}), 32'd0);
    chk("abort_wrIdx", 32'(o_wrIdx), 32'd0);
    chk("abort_wrData", o_wrData, 32'd0);
    chk("abort_cmpl", 32'({o_texComplete, o_clutComplete}), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    i_memDataValid = 1'b1;
    i_memData      = 32'h66660003;
    repeat (3) @(posedge clk);
    #1 i_memDataValid = 1'b0;

    // Clean Tex fill after the abort.
    push_fill(1'b0, 18'h00246, 2, 32'h77770000, 2);
    @(posedge clk); #1;
    i_adrTex  = 17'h00123;
    i_requTex = 1'b1;
    serve(1, 0, 2, 1'b0, 0); wait_cmpl(1'b0);
    @(posedge clk); #1 i_requTex = 1'b0;

    repeat (5) @(negedge clk);
    chk("wr_left", 32'(exp_wr_q.size()), 32'd0);
    chk("burst_left", 32'(exp_burst_q.size()), 32'd0);
    chk("end_busy", 32'(o_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
